// File: rtl/instr_decode_issue.sv
// Decode/issue stage: one registered issue slot, RAW/WAW scoreboard, HALT drain FSM.
// Optional feature: define DEC_ILLEGAL_TRAP_EN to trap illegal opcodes instead of issuing them as NOP.
module instr_decode_issue #(
    parameter int INSTR_W = 16,
    parameter int NREGS   = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_valid,
    input  logic [INSTR_W-1:0] if_instr,
    output logic               if_ready,
    output logic               ex_valid,
    input  logic               ex_ready,
    output logic [3:0]         ex_op,
    output logic [3:0]         ex_rd,
    output logic [7:0]         ex_imm,
    output logic               ex_reg_write,
    output logic [3:0]         read_reg1,
    output logic [3:0]         read_reg2,
    output logic               reg_enable,
    input  logic               wb_valid,
    input  logic [3:0]         wb_rd,
    output logic               halted,
    output logic               illegal_op
);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t             state, state_next;
    logic [NREGS-1:0]   scoreboard, sb_eff, sb_next, wb_mask, set_mask;
    logic [3:0]         op_in, rd_in, rs1_in, rs2_in, op_issue;
    logic               is_legal, writes_in, uses_rs1, uses_rs2;
    logic               hazard, slot_free, accept, trap_illegal, issue;

    always_comb begin
        op_in     = if_instr[15:12];
        rd_in     = if_instr[11:8];
        rs1_in    = if_instr[7:4];
        rs2_in    = if_instr[3:0];
        is_legal  = (op_in <= 4'd6) || (op_in == 4'hF);
        writes_in = (op_in >= 4'd1) && (op_in <= 4'd6);
        uses_rs1  = ((op_in >= 4'd1) && (op_in <= 4'd4)) || (op_in == 4'd6);
        uses_rs2  = (op_in >= 4'd1) && (op_in <= 4'd4);
        op_issue  = is_legal ? op_in : 4'd0;

        // A writeback this cycle releases its register before the hazard check.
        wb_mask   = wb_valid ? (NREGS'(1) << wb_rd) : '0;
        sb_eff    = scoreboard & ~wb_mask;
        hazard    = (writes_in & sb_eff[rd_in]) |
                    (uses_rs1  & sb_eff[rs1_in]) |
                    (uses_rs2  & sb_eff[rs2_in]);

        slot_free = ~ex_valid | ex_ready;
        if_ready  = (state == RUN) & slot_free & ~hazard;
        accept    = if_valid & if_ready;
`ifdef DEC_ILLEGAL_TRAP_EN
        trap_illegal = accept & ~is_legal;
`else
        trap_illegal = 1'b0;
`endif
        issue     = accept & ~trap_illegal;
        set_mask  = (accept & writes_in) ? (NREGS'(1) << rd_in) : '0;
        sb_next   = sb_eff | set_mask;
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN: begin
                if (trap_illegal)
                    state_next = HALTED;
                else if (accept && (op_in == 4'hF))
                    state_next = DRAIN;
            end
            DRAIN: begin
                if (slot_free && (sb_eff == '0))
                    state_next = HALTED;
            end
            HALTED:  state_next = HALTED;
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            scoreboard   <= '0;
            ex_valid     <= 1'b0;
            ex_op        <= 4'd0;
            ex_rd        <= 4'd0;
            ex_imm       <= 8'd0;
            ex_reg_write <= 1'b0;
            read_reg1    <= 4'd0;
            read_reg2    <= 4'd0;
        end else begin
            state      <= state_next;
            scoreboard <= sb_next;
            if (issue) begin
                ex_valid     <= 1'b1;
                ex_op        <= op_issue;
                ex_rd        <= rd_in;
                ex_imm       <= if_instr[7:0];
                ex_reg_write <= writes_in;
                read_reg1    <= rs1_in;
                read_reg2    <= rs2_in;
            end else if (ex_ready || (state_next == HALTED)) begin
                ex_valid <= 1'b0;
            end
        end
    end

`ifdef DEC_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            illegal_op <= 1'b0;
        else if (trap_illegal)
            illegal_op <= 1'b1;
    end
`else
    assign illegal_op = 1'b0;
`endif

    assign reg_enable = ex_valid;
    assign halted     = (state == HALTED);

endmodule

// File: tb/tb_instr_decode_issue.sv
// Randomized + directed bench for instr_decode_issue; a pending-set reference model
// predicts if_ready/halt behaviour and a monitor checks issued slots against exp_q.
module tb_instr_decode_issue;

`ifdef DEC_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk, rst_n;
    logic        if_valid, if_ready, ex_valid, ex_ready, ex_reg_write, reg_enable;
    logic [15:0] if_instr;
    logic [3:0]  ex_op, ex_rd, read_reg1, read_reg2, wb_rd;
    logic [7:0]  ex_imm;
    logic        wb_valid, halted, illegal_op;

    int n_cmp = 0;
    int n_bad = 0;

    // Expected slot contents: {op, rd, imm, reg_write, rs1, rs2}
    logic [24:0] exp_q[$];

    // Reference model state
    bit [15:0] m_pend;
    bit        m_slot, m_drain, m_halted, m_illegal;

    instr_decode_issue dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_rd(ex_rd),
        .ex_imm(ex_imm), .ex_reg_write(ex_reg_write),
        .read_reg1(read_reg1), .read_reg2(read_reg2), .reg_enable(reg_enable),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .halted(halted), .illegal_op(illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [24:0] exp_entry(input logic [15:0] ins);
        logic [3:0] op;
        op = ins[15:12];
        return {((op <= 4'd6) || (op == 4'hF)) ? op : 4'd0, ins[11:8], ins[7:0],
                (op >= 4'd1) && (op <= 4'd6), ins[7:4], ins[3:0]};
    endfunction

    task automatic model_clear();
        m_pend = '0; m_slot = 0; m_drain = 0; m_halted = 0; m_illegal = 0;
        exp_q.delete();
    endtask

    // One clock of stimulus; compares stage outputs with the model, then advances it.
    task automatic cycle(input bit v, input logic [15:0] ins, input bit rdy,
                         input bit wbv, input logic [3:0] wbr);
        int        op;
        bit        legal, wr, acc, trap, slot_done, exp_rdy;
        bit [15:0] need, eff;
        @(negedge clk);
        if_valid = v; if_instr = ins; ex_ready = rdy; wb_valid = wbv; wb_rd = wbr;
        #3;
        op    = int'(ins[15:12]);
        legal = (op <= 6) || (op == 15);
        wr    = (op >= 1) && (op <= 6);
        need  = '0;
        if (wr) need[ins[11:8]] = 1'b1;
        if ((op >= 1 && op <= 4) || op == 6) need[ins[7:4]] = 1'b1;
        if (op >= 1 && op <= 4) need[ins[3:0]] = 1'b1;
        eff = m_pend;
        if (wbv) eff[wbr] = 1'b0;
        exp_rdy = !m_halted && !m_drain && !(m_slot && !rdy) && ((need & eff) == '0);

        check("if_ready", 32'(if_ready), 32'(exp_rdy));
        check("ex_valid", 32'(ex_valid), 32'(m_slot));
        check("reg_enable", 32'(reg_enable), 32'(m_slot));
        check("halted", 32'(halted), 32'(m_halted));
        check("illegal_op", 32'(illegal_op), 32'(m_illegal));

        acc       = v && exp_rdy;
        trap      = acc && !legal && TRAP;
        slot_done = !m_slot || rdy;
        if (m_drain && slot_done && eff == '0) begin
            m_halted = 1; m_drain = 0;
        end
        m_pend = eff;
        if (acc && wr) m_pend[ins[11:8]] = 1'b1;
        if (acc && !trap) begin
            m_slot = 1;
            exp_q.push_back(exp_entry(ins));
        end else if (rdy) begin
            m_slot = 0;
        end
        if (acc && op == 15) m_drain = 1;
        if (trap) begin
            m_illegal = 1; m_halted = 1; m_slot = 0;
        end
        if (m_halted) m_slot = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 16'h0, 1, 0, 4'd0);
    endtask

    task automatic drain_pending();
        for (int r = 0; r < 16; r++)
            if (m_pend[r]) cycle(0, 16'h0, 1, 1, 4'(r));
    endtask

    // Asynchronous reset asserted between edges; outputs must clear immediately.
    task automatic reset_mid();
        @(negedge clk);
        if_valid = 0; wb_valid = 0; ex_ready = 1;
        #4 rst_n = 1'b0;
        #1;
        check("rst_ex_valid", 32'(ex_valid), 0);
        check("rst_ex_op", 32'(ex_op), 0);
        check("rst_ex_rd", 32'(ex_rd), 0);
        check("rst_ex_imm", 32'(ex_imm), 0);
        check("rst_ex_reg_write", 32'(ex_reg_write), 0);
        check("rst_read_reg1", 32'(read_reg1), 0);
        check("rst_read_reg2", 32'(read_reg2), 0);
        check("rst_reg_enable", 32'(reg_enable), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_illegal_op", 32'(illegal_op), 0);
        model_clear();
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: whenever the slot is valid it must match the oldest expected entry.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && ex_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL slot_unexpected: got op %0h rd %0h expected no issue (t=%0t)",
                         ex_op, ex_rd, $time);
            end else begin
                check("slot", 32'({ex_op, ex_rd, ex_imm, ex_reg_write, read_reg1, read_reg2}),
                      32'(exp_q[0]));
                if (ex_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int        r, halt_cnt;
        bit [15:0] ins;
        int        plist[$];
        rst_n = 1'b0; if_valid = 0; if_instr = '0; ex_ready = 1; wb_valid = 0; wb_rd = '0;
        model_clear();
        #12 rst_n = 1'b1;

        // ADD r3,r1,r2 issued, then held under backpressure and reset mid-run
        cycle(1, 16'h1312, 1, 0, 4'd0);
        cycle(1, 16'h1312, 0, 0, 4'd0);
        reset_mid();

        cycle(1, 16'h1312, 1, 0, 4'd0);
        idle(1);
        drain_pending();

        // LDI r4 then dependent ADD: blocked until writeback of r4 bypasses
        cycle(1, 16'h5407, 1, 0, 4'd0);
        cycle(1, 16'h1541, 1, 0, 4'd0);
        cycle(1, 16'h1541, 1, 0, 4'd0);
        cycle(1, 16'h1541, 1, 1, 4'd4);
        idle(1);
        drain_pending();

        // Backpressure: slot held three cycles
        cycle(1, 16'h6120, 1, 0, 4'd0);
        for (int i = 0; i < 3; i++) cycle(1, 16'h2656, 0, 0, 4'd0);
        cycle(1, 16'h2656, 1, 0, 4'd0);
        idle(2);
        drain_pending();

        // HALT behind pending r3
        cycle(1, 16'h1312, 1, 0, 4'd0);
        cycle(1, 16'hF000, 1, 0, 4'd0);
        cycle(1, 16'h0000, 1, 0, 4'd0);
        cycle(1, 16'h0000, 1, 0, 4'd0);
        cycle(0, 16'h0000, 1, 1, 4'd3);
        idle(2);
        reset_mid();

        // Illegal opcode 0x8
        cycle(1, 16'h8123, 1, 0, 4'd0);
        cycle(1, 16'h1312, 1, 0, 4'd0);
        idle(2);
        reset_mid();

        // Randomized traffic
        halt_cnt = 0;
        for (int it = 0; it < 4000; it++) begin
            r = $urandom_range(0, 99);
            if (r < 85)      ins[15:12] = 4'($urandom_range(0, 6));
            else if (r < 93) ins[15:12] = 4'($urandom_range(7, 14));
            else             ins[15:12] = 4'hF;
            ins[11:8] = 4'($urandom_range(0, 7));
            ins[7:0]  = 8'($urandom_range(0, 255)) & 8'h77;
            plist.delete();
            for (int k = 0; k < 16; k++) if (m_pend[k]) plist.push_back(k);
            if (plist.size() > 0 && $urandom_range(0, 99) < 45)
                cycle($urandom_range(0, 99) < 70, ins, $urandom_range(0, 3) != 0, 1,
                      4'(plist[$urandom_range(0, plist.size() - 1)]));
            else
                cycle($urandom_range(0, 99) < 70, ins, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 9) == 0, 4'($urandom_range(0, 15)));
            halt_cnt = m_halted ? halt_cnt + 1 : 0;
            if (halt_cnt > 3) begin
                reset_mid();
                halt_cnt = 0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
